// File: rtl/vx_lsu_mem_responder.sv
// LSU memory slave: per-lane byte-enabled flop memory with an in-order tagged read-response queue.
// Define LMEM_WRITE_ACK_EN to make accepted writes also return a response entry (data=0).
module vx_lsu_mem_responder #(
    parameter int NUM_LANES       = 4,
    parameter int DATA_SIZE       = 4,
    parameter int TAG_WIDTH       = 8,
    parameter int FLAGS_WIDTH     = 3,
    parameter int ADDR_WIDTH      = 30,
    parameter int DEPTH           = 256,
    parameter int RSP_QUEUE_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    input  logic [NUM_LANES-1:0]                 req_mask,
    input  logic                                 req_rw,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_LANES*DATA_SIZE*8-1:0]     req_data,
    input  logic [NUM_LANES*DATA_SIZE-1:0]       req_byteen,
    input  logic [NUM_LANES*FLAGS_WIDTH-1:0]     req_flags,
    input  logic [TAG_WIDTH-1:0]                 req_tag,
    output logic                                 req_ready,
    output logic                                 rsp_valid,
    output logic [NUM_LANES-1:0]                 rsp_mask,
    output logic [NUM_LANES*DATA_SIZE*8-1:0]     rsp_data,
    output logic [TAG_WIDTH-1:0]                 rsp_tag,
    input  logic                                 rsp_ready
);

    localparam int WORD_W  = DATA_SIZE * 8;
    localparam int LINE_W  = NUM_LANES * WORD_W;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W   = (RSP_QUEUE_DEPTH > 1) ? $clog2(RSP_QUEUE_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RSP_QUEUE_DEPTH + 1);

    logic [WORD_W-1:0]    mem_q    [DEPTH];
    logic [WORD_W-1:0]    mem_d    [DEPTH];
    logic [NUM_LANES-1:0] q_mask_q [RSP_QUEUE_DEPTH];
    logic [NUM_LANES-1:0] q_mask_d [RSP_QUEUE_DEPTH];
    logic [LINE_W-1:0]    q_data_q [RSP_QUEUE_DEPTH];
    logic [LINE_W-1:0]    q_data_d [RSP_QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0] q_tag_q  [RSP_QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0] q_tag_d  [RSP_QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic [LINE_W-1:0] rd_data;
    logic [LINE_W-1:0] push_data;

    logic unused_inputs;
    assign unused_inputs = ^{req_flags, req_addr};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_QUEUE_DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Ready comes only from registered occupancy, so no combinational path from rsp_ready.
    assign req_ready = (count_q < CNT_W'(RSP_QUEUE_DEPTH));
    assign rsp_valid = (count_q != '0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

`ifdef LMEM_WRITE_ACK_EN
    assign push      = accept;
    assign push_data = req_rw ? '0 : rd_data;
`else
    assign push      = accept && !req_rw;
    assign push_data = rd_data;
`endif

    // Queue storage is not reset, so outputs are gated to read as zero while empty.
    assign rsp_mask = rsp_valid ? q_mask_q[rd_ptr_q] : '0;
    assign rsp_data = rsp_valid ? q_data_q[rd_ptr_q] : '0;
    assign rsp_tag  = rsp_valid ? q_tag_q[rd_ptr_q]  : '0;

    always_comb begin
        rd_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (req_mask[l])
                rd_data[l*WORD_W +: WORD_W] = mem_q[req_addr[l*ADDR_WIDTH +: IDX_W]];
        end
    end

    // Lanes are applied in ascending order so the highest lane wins on a shared byte.
    always_comb begin
        mem_d = mem_q;
        if (accept && req_rw) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int b = 0; b < DATA_SIZE; b++) begin
                    if (req_mask[l] && req_byteen[l*DATA_SIZE + b])
                        mem_d[req_addr[l*ADDR_WIDTH +: IDX_W]][b*8 +: 8] =
                            req_data[(l*DATA_SIZE + b)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        q_mask_d = q_mask_q;
        q_data_d = q_data_q;
        q_tag_d  = q_tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            q_mask_d[wr_ptr_q] = req_mask;
            q_data_d[wr_ptr_q] = push_data;
            q_tag_d[wr_ptr_q]  = req_tag;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        q_mask_q <= q_mask_d;
        q_data_q <= q_data_d;
        q_tag_q  <= q_tag_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_vx_lsu_mem_responder.sv
// Scoreboard bench for vx_lsu_mem_responder: a reference memory predicts every response.
module tb_vx_lsu_mem_responder;

    localparam int NL  = 4;
    localparam int DS  = 4;
    localparam int TW  = 8;
    localparam int FW  = 3;
    localparam int AW  = 30;
    localparam int DEP = 256;
    localparam int RQ  = 2;
    localparam int WW  = DS * 8;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [NL-1:0]     req_mask;
    logic              req_rw;
    logic [NL*AW-1:0]  req_addr;
    logic [NL*WW-1:0]  req_data;
    logic [NL*DS-1:0]  req_byteen;
    logic [NL*FW-1:0]  req_flags;
    logic [TW-1:0]     req_tag;
    logic              req_ready;
    logic              rsp_valid;
    logic [NL-1:0]     rsp_mask;
    logic [NL*WW-1:0]  rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic              rsp_ready;

    typedef struct packed {
        logic [NL-1:0]    mask;
        logic [NL*WW-1:0] data;
        logic [TW-1:0]    tag;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        last_rsp;
    logic [WW-1:0] mem_m [DEP];
    int          checks = 0;
    int          errors = 0;
    logic        rand_en = 1'b0;

    vx_lsu_mem_responder #(
        .NUM_LANES(NL), .DATA_SIZE(DS), .TAG_WIDTH(TW), .FLAGS_WIDTH(FW),
        .ADDR_WIDTH(AW), .DEPTH(DEP), .RSP_QUEUE_DEPTH(RQ)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_mask(req_mask), .req_rw(req_rw), .req_addr(req_addr),
        .req_data(req_data), .req_byteen(req_byteen), .req_flags(req_flags), .req_tag(req_tag),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NL*AW-1:0] a4(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NL*WW-1:0] d4(input logic [31:0] d0, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 128'(sb.size()), 128'd1);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_mask", 128'(rsp_mask), 128'(e.mask));
                check("rsp_data", 128'(rsp_data), 128'(e.data));
                check("rsp_tag",  128'(rsp_tag),  128'(e.tag));
                last_rsp = {rsp_mask, rsp_data, rsp_tag};
            end
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic rw, input logic [NL-1:0] mask, input logic [NL*AW-1:0] addr,
                        input logic [NL*WW-1:0] data, input logic [NL*DS-1:0] be,
                        input logic [TW-1:0] tag);
        int   n;
        rsp_t e;
        n          = 0;
        req_rw     = rw;
        req_mask   = mask;
        req_addr   = addr;
        req_data   = data;
        req_byteen = be;
        req_tag    = tag;
        req_flags  = (NL*FW)'($urandom);
        req_valid  = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_timeout", 128'(req_ready), 128'd1);
        end else if (rw) begin
            for (int l = 0; l < NL; l++)
                for (int b = 0; b < DS; b++)
                    if (mask[l] && be[l*DS + b])
                        mem_m[addr[l*AW +: 8]][b*8 +: 8] = data[(l*DS + b)*8 +: 8];
`ifdef LMEM_WRITE_ACK_EN
            e.mask = mask;
            e.data = '0;
            e.tag  = tag;
            sb.push_back(e);
`endif
        end else begin
            e.mask = mask;
            e.tag  = tag;
            e.data = '0;
            for (int l = 0; l < NL; l++)
                if (mask[l])
                    e.data[l*WW +: WW] = mem_m[addr[l*AW +: 8]];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_mask   = '0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_byteen = '0;
        req_flags  = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_rsp_mask",  128'(rsp_mask),  128'd0);
        check("rst_rsp_data",  128'(rsp_data),  128'd0);
        check("rst_rsp_tag",   128'(rsp_tag),   128'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int w = 0; w < DEP / NL; w++)
            send(1'b1, 4'hF, a4(4*w, 4*w+1, 4*w+2, 4*w+3),
                 d4($urandom, $urandom, $urandom, $urandom), 16'hFFFF, 8'h00);
        wait_drain();

        // Basic write then read, one-cycle latency.
        send(1'b1, 4'h1, a4(5, 0, 0, 0), d4(32'hDEADBEEF, 0, 0, 0), 16'h000F, 8'h01);
        send(1'b0, 4'h1, a4(5, 0, 0, 0), '0, '0, 8'h3C);
        check("lat_rsp_valid", 128'(rsp_valid), 128'd1);
        check("lat_rsp_mask",  128'(rsp_mask),  128'h1);
        check("lat_rsp_data0", 128'(rsp_data[31:0]), 128'hDEADBEEF);
        check("lat_rsp_tag",   128'(rsp_tag),   128'h3C);
        wait_drain();

        // Partial byte-enable merge.
        send(1'b1, 4'h1, a4(7, 0, 0, 0), d4(32'h11223344, 0, 0, 0), 16'h000F, 8'h02);
        send(1'b1, 4'h1, a4(7, 0, 0, 0), d4(32'h0000AA00, 0, 0, 0), 16'h0002, 8'h03);
        send(1'b0, 4'h1, a4(7, 0, 0, 0), '0, '0, 8'h41);
        wait_drain();
        check("byteen_merge", 128'(last_rsp.data[31:0]), 128'h1122AA44);

        // Same-index collision: highest active lane wins; lane 1 is masked off.
        send(1'b1, 4'h5, a4(9, 9, 9, 0), d4(32'h1, 32'h55, 32'h2, 0), 16'hFFFF, 8'h04);
        send(1'b0, 4'h1, a4(9, 0, 0, 0), '0, '0, 8'h42);
        wait_drain();
        check("lane_collision", 128'(last_rsp.data[31:0]), 128'h2);

        // Backpressure: queue fills at two entries, head held stable.
        rsp_ready = 1'b0;
        send(1'b0, 4'hF, a4(1, 2, 3, 4), '0, '0, 8'h50);
        send(1'b0, 4'hF, a4(5, 6, 7, 8), '0, '0, 8'h51);
        check("full_req_ready", 128'(req_ready), 128'd0);
        check("full_head_tag",  128'(rsp_tag),   128'h50);
        @(posedge clk);
        #1;
        check("hold_rsp_valid", 128'(rsp_valid), 128'd1);
        check("hold_head_tag",  128'(rsp_tag),   128'h50);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("full_ready_rsp_ready", 128'(req_ready), 128'd0);
        send(1'b0, 4'hF, a4(9, 10, 11, 12), '0, '0, 8'h52);
        wait_drain();
        check("order_last_tag", 128'(last_rsp.tag), 128'h52);

        // Address aliasing above the index bits.
        send(1'b1, 4'h1, a4(3, 0, 0, 0), d4(32'hCAFEF00D, 0, 0, 0), 16'h000F, 8'h05);
        send(1'b0, 4'h3, a4(3, 259, 0, 0), '0, '0, 8'h60);
        wait_drain();
        check("alias_lane1", 128'(last_rsp.data[63:32]), 128'hCAFEF00D);
        check("alias_lane0", 128'(last_rsp.data[31:0]),  128'hCAFEF00D);

        // Sparse mask: inactive lanes return zero.
        send(1'b0, 4'hA, a4(5, 7, 9, 3), '0, '0, 8'h61);
        wait_drain();
        check("mask_a_mask",  128'(last_rsp.mask), 128'hA);
        check("mask_a_lane0", 128'(last_rsp.data[31:0]),   128'h0);
        check("mask_a_lane1", 128'(last_rsp.data[63:32]),  128'h1122AA44);
        check("mask_a_lane2", 128'(last_rsp.data[95:64]),  128'h0);
        check("mask_a_lane3", 128'(last_rsp.data[127:96]), 128'hCAFEF00D);

        // Zero-mask read still responds.
        send(1'b0, 4'h0, a4(5, 7, 9, 3), '0, '0, 8'h62);
        wait_drain();
        check("mask0_tag",  128'(last_rsp.tag),  128'h62);
        check("mask0_mask", 128'(last_rsp.mask), 128'h0);

`ifdef LMEM_WRITE_ACK_EN
        send(1'b1, 4'h3, a4(20, 21, 0, 0), d4(32'h12345678, 32'h9ABCDEF0, 0, 0), 16'hFFFF, 8'h07);
        check("wack_valid", 128'(rsp_valid), 128'd1);
        check("wack_tag",   128'(rsp_tag),   128'h07);
        check("wack_data",  128'(rsp_data),  128'h0);
        check("wack_mask",  128'(rsp_mask),  128'h3);
        wait_drain();
`endif

        // Random mix with random response backpressure.
        rand_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [NL*AW-1:0] ra;
            for (int l = 0; l < NL; l++)
                ra[l*AW +: AW] = AW'($urandom);
            send(1'($urandom_range(0, 1)), NL'($urandom), ra,
                 d4($urandom, $urandom, $urandom, $urandom), (NL*DS)'($urandom), TW'(i));
        end
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with queued responses.
        rsp_ready = 1'b0;
        send(1'b0, 4'hF, a4(1, 2, 3, 4), '0, '0, 8'h70);
        send(1'b0, 4'hF, a4(5, 6, 7, 8), '0, '0, 8'h71);
        check("pre_reset_valid", 128'(rsp_valid), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_rsp_valid", 128'(rsp_valid), 128'd0);
        check("areset_req_ready", 128'(req_ready), 128'd1);
        check("areset_rsp_tag",   128'(rsp_tag),   128'd0);
        sb.delete();
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, 4'h1, a4(5, 0, 0, 0), '0, '0, 8'h72);
        wait_drain();
        check("post_reset_tag", 128'(last_rsp.tag), 128'h72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
